tlul_txn_monitor: RTL

- Passive, parametrised TL-UL bus monitor. Taps the unpacked A/D channel fields of one host-device link and never drives the bus.
- Tracks outstanding requests by source ID, pairs responses with their requests, and measures per-transaction latency.
- Flags protocol violations in sticky error bits and keeps saturating statistics counters.
- Used in fuzzing/simulation testbenches, one instance per monitored link.

---
 rtl/tlul_txn_monitor.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_txn_monitor.sv
// Passive TL-UL link monitor: tracks outstanding requests by source ID, pairs
// responses, measures latency, and keeps sticky protocol errors and counters.
module tlul_txn_monitor #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned AIW     = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LAT_W   = 8,
  parameter int unsigned TIMEOUT = 100
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         a_valid_i,
  input  logic                         a_ready_i,
  input  logic [2:0]                   a_opcode_i,
  input  logic [AIW-1:0]               a_source_i,
  input  logic [AW-1:0]                a_address_i,
  input  logic [DW/8-1:0]              a_mask_i,
  input  logic [DW-1:0]                a_data_i,
  input  logic                         d_valid_i,
  input  logic                         d_ready_i,
  input  logic [2:0]                   d_opcode_i,
  input  logic [AIW-1:0]               d_source_i,
  input  logic                         d_error_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic [CNT_W-1:0]             req_cnt_o,
  output logic [CNT_W-1:0]             rsp_cnt_o,
  output logic [CNT_W-1:0]             err_rsp_cnt_o,
  output logic [LAT_W-1:0]             last_lat_o,
  output logic [LAT_W-1:0]             max_lat_o,
  output logic [6:0]                   err_o,
  output logic                         err_any_o
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  // Handshake: a beat transfers on a channel in any cycle where valid and
  // ready are both high; while valid is high and ready low, the sender must
  // keep valid asserted and every payload field unchanged.
  logic a_fire;
  logic d_fire;
  assign a_fire = a_valid_i & a_ready_i;
  assign d_fire = d_valid_i & d_ready_i;

  // Outstanding table
  logic [DEPTH-1:0] ent_valid;
  logic [AIW-1:0]   ent_source [DEPTH];
  logic [2:0]       ent_opcode [DEPTH];
  logic [LAT_W-1:0] ent_age    [DEPTH];

  // Stall capture of the previous A-channel cycle
  logic              stall_q;
  logic [2:0]        a_opcode_q;
  logic [AIW-1:0]    a_source_q;
  logic [AW-1:0]     a_address_q;
  logic [DW/8-1:0]   a_mask_q;
  logic [DW-1:0]     a_data_q;

  logic              a_legal;
  logic              table_full;
  logic              dup_hit;
  logic              match_hit;
  logic              timeout_hit;
  logic              op_mismatch;
  logic              unstable;
  logic [IW-1:0]     alloc_idx;
  logic [IW-1:0]     match_idx;
  logic [LAT_W-1:0]  match_age;
  logic [LAT_W-1:0]  match_lat;
  logic [2:0]        exp_d_opcode;
  logic [DEPTH-1:0]  alloc_vec;
  logic [DEPTH-1:0]  free_vec;
  logic [DEPTH-1:0]  valid_next;
  logic [OW-1:0]     outstanding_next;

  assign a_legal    = (a_opcode_i == OP_PUT_FULL) | (a_opcode_i == OP_PUT_PARTIAL) |
                      (a_opcode_i == OP_GET);
  assign table_full = &ent_valid;

  // Lookups use only pre-cycle table state; the descending loop leaves the
  // lowest qualifying index in alloc_idx / match_idx.
  always_comb begin
    alloc_idx   = '0;
    match_idx   = '0;
    match_hit   = 1'b0;
    dup_hit     = 1'b0;
    timeout_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = IW'(i);
      if (ent_valid[i] && (ent_source[i] == d_source_i)) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_source[i] == a_source_i)) dup_hit = 1'b1;
      if ((TIMEOUT != 0) && ent_valid[i] && (32'(ent_age[i]) == TIMEOUT)) timeout_hit = 1'b1;
    end
  end

  always_comb begin
    match_age    = ent_age[match_idx];
    match_lat    = (&match_age) ? match_age : match_age + LAT_W'(1);
    exp_d_opcode = (ent_opcode[match_idx] == OP_GET) ? OP_ACK_DATA : OP_ACK;
    op_mismatch  = (d_opcode_i != exp_d_opcode);
  end

  always_comb begin
    alloc_vec        = '0;
    free_vec         = '0;
    outstanding_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_vec[i] = a_fire & a_legal & ~table_full & (alloc_idx == IW'(i));
      free_vec[i]  = d_fire & match_hit & (match_idx == IW'(i));
    end
    valid_next = (ent_valid & ~free_vec) | alloc_vec;
    for (int i = 0; i < DEPTH; i++) begin
      outstanding_next = outstanding_next + OW'(valid_next[i]);
    end
  end

  assign unstable = stall_q & (~a_valid_i | (a_opcode_i != a_opcode_q) |
                               (a_source_i != a_source_q) | (a_address_i != a_address_q) |
                               (a_mask_i != a_mask_q) | (a_data_i != a_data_q));

  // Clear is applied first, then this cycle's events land on top of it.
  logic [CNT_W-1:0] req_base, rsp_base, ersp_base;
  logic [CNT_W-1:0] req_next, rsp_next, ersp_next;
  logic [LAT_W-1:0] last_next, max_base, max_next;
  logic [6:0]       err_event, err_next;

  always_comb begin
    req_base  = clr_i ? '0 : req_cnt_o;
    rsp_base  = clr_i ? '0 : rsp_cnt_o;
    ersp_base = clr_i ? '0 : err_rsp_cnt_o;
    req_next  = (a_fire && !(&req_base)) ? req_base + CNT_W'(1) : req_base;
    rsp_next  = (d_fire && !(&rsp_base)) ? rsp_base + CNT_W'(1) : rsp_base;
    ersp_next = (d_fire && d_error_i && !(&ersp_base)) ? ersp_base + CNT_W'(1) : ersp_base;

    last_next = clr_i ? '0 : last_lat_o;
    max_base  = clr_i ? '0 : max_lat_o;
    max_next  = max_base;
    if (d_fire && match_hit) begin
      last_next = match_lat;
      max_next  = (match_lat > max_base) ? match_lat : max_base;
    end

    err_event = {timeout_hit,
                 a_fire & ~a_legal,
                 a_fire & dup_hit,
                 unstable,
                 d_fire & match_hit & op_mismatch,
                 d_fire & ~match_hit,
                 a_fire & table_full};
    err_next  = (clr_i ? 7'd0 : err_o) | err_event;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_source[i] <= '0;
        ent_opcode[i] <= '0;
        ent_age[i]    <= '0;
      end
    end else begin
      ent_valid <= valid_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_vec[i]) begin
          ent_source[i] <= a_source_i;
          ent_opcode[i] <= a_opcode_i;
          ent_age[i]    <= '0;
        end else if (free_vec[i]) begin
          ent_age[i]    <= '0;
        end else if (ent_valid[i] && !(&ent_age[i])) begin
          ent_age[i]    <= ent_age[i] + LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q     <= 1'b0;
      a_opcode_q  <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else begin
      stall_q     <= a_valid_i & ~a_ready_i;
      a_opcode_q  <= a_opcode_i;
      a_source_q  <= a_source_i;
      a_address_q <= a_address_i;
      a_mask_q    <= a_mask_i;
      a_data_q    <= a_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_o <= '0;
      req_cnt_o     <= '0;
      rsp_cnt_o     <= '0;
      err_rsp_cnt_o <= '0;
      last_lat_o    <= '0;
      max_lat_o     <= '0;
      err_o         <= '0;
      err_any_o     <= 1'b0;
    end else begin
      outstanding_o <= outstanding_next;
      req_cnt_o     <= req_next;
      rsp_cnt_o     <= rsp_next;
      err_rsp_cnt_o <= ersp_next;
      last_lat_o    <= last_next;
      max_lat_o     <= max_next;
      err_o         <= err_next;
      err_any_o     <= |err_next;
    end
  end

endmodule
